// File: rtl/detector_jogada.sv
// Input stage of the memory game. It synchronises and debounces the raw keys,
// checks that exactly one key is pressed, and reports each accepted play once
// as a one-cycle jogada_feita strobe together with the registered one-hot code.
module detector_jogada #(
   parameter int N_CHAVES        = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CW              = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_CHAVES-1:0] chaves,
   input  logic                habilita,
   input  logic                limpa,
   output logic [N_CHAVES-1:0] jogada,
   output logic                jogada_feita,
   output logic                jogada_invalida,
   output logic [N_CHAVES-1:0] db_chaves_filtradas,
   output logic [3:0]          db_estado
);

   typedef enum logic [3:0] {
      SOLTO         = 4'd0,
      PRESSIONADO   = 4'd1,
      ESPERA_SOLTAR = 4'd2
   } estado_t;

   // Last count value before the filtered bit toggles.
   localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_CHAVES-1:0] sync_p0;
   logic [N_CHAVES-1:0] sync_p1;
   logic [N_CHAVES-1:0] filt;
   logic [CW-1:0]       cnt [N_CHAVES];

   estado_t             estado;
   estado_t             estado_next;
   logic [N_CHAVES-1:0] jogada_next;
   logic                feita_next;
   logic                invalida_next;

   // True when exactly one key is set.
   function automatic logic um_so(input logic [N_CHAVES-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Two-flop synchroniser per key.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= chaves;
         sync_p1 <= sync_p0;
      end
   end

   // Per-key debounce: toggle filt after DEBOUNCE_CYCLES consecutive disagreements.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         filt <= '0;
         for (int i = 0; i < N_CHAVES; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_CHAVES; i++) begin
            if (sync_p1[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_ULTIMO) begin
               filt[i] <= ~filt[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Next-state and registered-output logic of the press FSM.
   always_comb begin
      estado_next   = estado;
      jogada_next   = limpa ? '0 : jogada;
      feita_next    = 1'b0;
      invalida_next = 1'b0;
      case (estado)
         SOLTO: begin
            if (filt != '0) begin
               if (um_so(filt)) begin
                  if (habilita) begin
                     // An accepted play overrides a simultaneous limpa.
                     jogada_next = filt;
                     feita_next  = 1'b1;
                     estado_next = PRESSIONADO;
                  end else begin
                     estado_next = ESPERA_SOLTAR;
                  end
               end else begin
                  invalida_next = habilita;
                  estado_next   = ESPERA_SOLTAR;
               end
            end
         end
         PRESSIONADO: begin
            if (filt == '0)       estado_next = SOLTO;
            else if (!um_so(filt)) estado_next = ESPERA_SOLTAR;
         end
         ESPERA_SOLTAR: begin
            if (filt == '0) estado_next = SOLTO;
         end
         default: estado_next = SOLTO;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado          <= SOLTO;
         jogada          <= '0;
         jogada_feita    <= 1'b0;
         jogada_invalida <= 1'b0;
      end else begin
         estado          <= estado_next;
         jogada          <= jogada_next;
         jogada_feita    <= feita_next;
         jogada_invalida <= invalida_next;
      end
   end

   assign db_chaves_filtradas = filt;
   assign db_estado           = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a short debounce window; strobes are
// matched against a queue of expected events (cycle, kind, play code).
module tb_detector_jogada;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] chaves = 4'b0000;
   logic       habilita = 1'b0;
   logic       limpa = 1'b0;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       jogada_invalida;
   logic [3:0] db_chaves_filtradas;
   logic [3:0] db_estado;

   typedef struct {
      int         cyc;
      logic       inval;
      logic [3:0] jog;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   detector_jogada #(
      .N_CHAVES(4),
      .DEBOUNCE_CYCLES(4),
      .CW(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .chaves(chaves),
      .habilita(habilita),
      .limpa(limpa),
      .jogada(jogada),
      .jogada_feita(jogada_feita),
      .jogada_invalida(jogada_invalida),
      .db_chaves_filtradas(db_chaves_filtradas),
      .db_estado(db_estado)
   );

   // 10 ns clock.
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int dly, input logic inv, input logic [3:0] j);
      exp_t e;
      e.cyc   = cyc + dly;
      e.inval = inv;
      e.jog   = j;
      sb.push_back(e);
   endtask

   // Advance one clock, sample 1 ns after the edge and match any strobe.
   task automatic tick();
      exp_t e;
      logic st;
      @(posedge clock);
      cyc++;
      #1;
      st = jogada_feita | jogada_invalida;
      if (st) begin
         if (sb.size() == 0) begin
            chk("spurious_strobe", 32'(st), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
            chk("strobe_invalida", 32'(jogada_invalida), 32'(e.inval));
            chk("strobe_feita", 32'(jogada_feita), 32'(!e.inval));
            chk("strobe_jogada", 32'(jogada), 32'(e.jog));
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("missing_strobe", 32'(st), 32'd1);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      // Reset state
      ticks(2);
      chk("rst_jogada", 32'(jogada), 32'd0);
      chk("rst_feita", 32'(jogada_feita), 32'd0);
      chk("rst_invalida", 32'(jogada_invalida), 32'd0);
      chk("rst_filt", 32'(db_chaves_filtradas), 32'd0);
      chk("rst_estado", 32'(db_estado), 32'd0);
      reset = 1'b1;
      ticks(3);

      // Valid press held 20 cycles
      habilita = 1'b1;
      chaves   = 4'b0100;
      push(7, 1'b0, 4'b0100);
      ticks(6);
      chk("p1_estado_pre", 32'(db_estado), 32'd0);
      tick();
      chk("p1_estado_press", 32'(db_estado), 32'd1);
      chk("p1_jogada", 32'(jogada), 32'h4);
      ticks(13);
      chaves = 4'b0000;
      ticks(6);
      chk("p1_filt_rel", 32'(db_chaves_filtradas), 32'd0);
      chk("p1_estado_held", 32'(db_estado), 32'd1);
      tick();
      chk("p1_estado_rel", 32'(db_estado), 32'd0);
      chk("p1_jogada_hold", 32'(jogada), 32'h4);
      ticks(3);

      // Bounce on key 0
      for (int k = 0; k < 6; k++) begin
         chaves = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         for (int j = 0; j < 2; j++) begin
            tick();
            chk("bounce_filt", 32'(db_chaves_filtradas), 32'd0);
            chk("bounce_estado", 32'(db_estado), 32'd0);
         end
      end
      chaves = 4'b0000;
      ticks(8);
      chk("bounce_filt_end", 32'(db_chaves_filtradas), 32'd0);

      // Invalid two-key press
      chaves = 4'b1001;
      push(7, 1'b1, 4'b0100);
      ticks(7);
      chk("inv_estado", 32'(db_estado), 32'd2);
      ticks(5);
      chk("inv_estado_hold", 32'(db_estado), 32'd2);
      chk("inv_jogada", 32'(jogada), 32'h4);
      chaves = 4'b0000;
      ticks(7);
      chk("inv_estado_rel", 32'(db_estado), 32'd0);

      // Disabled press, enable raised while held
      habilita = 1'b0;
      chaves   = 4'b0010;
      ticks(7);
      chk("dis_estado", 32'(db_estado), 32'd2);
      habilita = 1'b1;
      ticks(6);
      chk("dis_estado_en", 32'(db_estado), 32'd2);
      chaves = 4'b0000;
      ticks(7);
      chk("dis_estado_rel", 32'(db_estado), 32'd0);
      chaves = 4'b0010;
      push(7, 1'b0, 4'b0010);
      ticks(7);
      chk("dis_repress_jogada", 32'(jogada), 32'h2);
      chk("dis_repress_estado", 32'(db_estado), 32'd1);
      ticks(5);
      chaves = 4'b0000;
      ticks(7);

      // Extra key while held, then limpa
      chaves = 4'b0001;
      push(7, 1'b0, 4'b0001);
      ticks(7);
      chk("ext_estado_press", 32'(db_estado), 32'd1);
      chaves = 4'b0101;
      ticks(6);
      chk("ext_estado_pre", 32'(db_estado), 32'd1);
      tick();
      chk("ext_estado_extra", 32'(db_estado), 32'd2);
      chk("ext_jogada", 32'(jogada), 32'h1);
      limpa = 1'b1;
      tick();
      limpa = 1'b0;
      chk("limpa_jogada", 32'(jogada), 32'd0);
      chk("limpa_estado", 32'(db_estado), 32'd2);
      chaves = 4'b0000;
      ticks(7);
      chk("ext_estado_rel", 32'(db_estado), 32'd0);

      // limpa held across an accepted play: the play wins that cycle
      limpa  = 1'b1;
      chaves = 4'b1000;
      push(7, 1'b0, 4'b1000);
      ticks(8);
      chk("limpa_after_play", 32'(jogada), 32'd0);
      limpa  = 1'b0;
      chaves = 4'b0000;
      ticks(7);

      // Async reset in the middle of a debounce
      chaves = 4'b0010;
      push(7, 1'b0, 4'b0010);
      ticks(7);
      chaves = 4'b0000;
      ticks(7);
      chaves = 4'b1000;
      ticks(3);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_jogada", 32'(jogada), 32'd0);
      chk("arst_feita", 32'(jogada_feita), 32'd0);
      chk("arst_invalida", 32'(jogada_invalida), 32'd0);
      chk("arst_filt", 32'(db_chaves_filtradas), 32'd0);
      chk("arst_estado", 32'(db_estado), 32'd0);
      ticks(3);
      reset = 1'b1;
      push(7, 1'b0, 4'b1000);
      ticks(6);
      chk("arst_estado_pre", 32'(db_estado), 32'd0);
      tick();
      chk("arst_estado_press", 32'(db_estado), 32'd1);
      chaves = 4'b0000;
      ticks(8);
      chk("pending_strobes", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input stage of the memory game. Sits between the raw `chaves` switches/buttons and the game datapath.
- Synchronises and debounces each key, checks that exactly one key is pressed, and emits a one-cycle `jogada_feita` strobe with the registered one-hot play code.
- Its outputs replace the datapath's internal edge detector: `jogada` feeds the play register and comparator, `jogada_feita` feeds the control unit.

Parameters:
- N_CHAVES, 4, number of keys; all key-wide ports are N_CHAVES bits.
- DEBOUNCE_CYCLES, 50000, number of consecutive cycles a synchronised key must differ from its filtered value before the filtered value toggles (1 ms at 50 MHz). Legal range is 2 or more.
- CW, 16, width of each debounce counter. Requires 2^CW > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- chaves  in  N_CHAVES  raw asynchronous keys, active-high.
- habilita  in  1  when 1, a valid press generates `jogada_feita`; when 0, presses are tracked but never reported.
- limpa  in  1  synchronous clear of `jogada` to 0.
- jogada  out  N_CHAVES  last accepted one-hot play; held until the next accepted play, `limpa`, or reset.
- jogada_feita  out  1  one-cycle strobe, asserted in the same cycle `jogada` takes its new value.
- jogada_invalida  out  1  one-cycle strobe: two or more keys were seen pressed from SOLTO while `habilita` = 1.
- db_chaves_filtradas  out  N_CHAVES  debounced key levels.
- db_estado  out  4  FSM state code: SOLTO=0, PRESSIONADO=1, ESPERA_SOLTAR=2.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - synchroniser flops, counters, filtered bits and `jogada` all clear to 0;
  - state goes to SOLTO;
  - `jogada_feita` = 0 and `jogada_invalida` = 0.
- Synchroniser: two flops per key. `sync[i]` is `chaves[i]` delayed by 2 cycles.
- Debounce, independent per key:
  - If `sync[i]` == `filt[i]`, `cnt[i]` clears to 0.
  - Otherwise `cnt[i]` increments. When it would reach DEBOUNCE_CYCLES, `filt[i]` toggles and `cnt[i]` clears instead.
  - Net effect: `filt[i]` changes exactly DEBOUNCE_CYCLES cycles after `sync[i]` first differs and stays different.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches `filt`.
  - Latency from a stable raw edge to the `filt` edge is DEBOUNCE_CYCLES+2.
- FSM, evaluated on `filt` (F), registered outputs:
  - SOLTO, F = 0: stay.
  - SOLTO, F one-hot, `habilita` = 1: load `jogada` <= F, pulse `jogada_feita`, go to PRESSIONADO.
  - SOLTO, F one-hot, `habilita` = 0: go to ESPERA_SOLTAR with no pulse.
  - SOLTO, F has two or more bits set: pulse `jogada_invalida` if `habilita` = 1, go to ESPERA_SOLTAR.
  - PRESSIONADO, F = 0: go to SOLTO.
  - PRESSIONADO, extra keys appear: go to ESPERA_SOLTAR, no pulse; the accepted play stands.
  - ESPERA_SOLTAR, F = 0: go to SOLTO; otherwise stay.
- Strobe timing: `jogada_feita` / `jogada_invalida` are high in the cycle after F first shows the pressed pattern, i.e. DEBOUNCE_CYCLES+3 cycles after a stable raw press.
- Each physical press produces at most one strobe. A key held indefinitely produces exactly one.
- `habilita` rising while a key is held in ESPERA_SOLTAR produces no pulse; the key must be released and pressed again.
- `limpa`:
  - zeroes `jogada` the next cycle; FSM state is unaffected.
  - If `limpa` and an accepted play occur in the same cycle, the new play wins.
- Near-simultaneous presses: filtered bits settle independently, so keys whose filtered edges land in different cycles are treated as a single press followed by extra keys (PRESSIONADO, then ESPERA_SOLTAR). This is accepted behaviour.
- Key held through reset release: `filt` is 0 after reset, so the key is detected as a fresh press after debounce, and fires if `habilita` = 1.
- Reset mid-debounce discards all partial counts.

Test Plan (DEBOUNCE_CYCLES=4):
- Valid press: after reset release, `habilita` = 1, `chaves` = 0100 held 20 cycles, then 0000. Expect `jogada_feita` high for exactly 1 cycle, 7 cycles after the raw edge; `jogada` = 0100 held; `db_estado` 0→1→0. No further pulse while held.
- Bounce rejection: `chaves[0]` toggles every 2 cycles for 12 cycles, then goes to 0. Expect `filt` = 0 throughout, no strobes, state stays 0.
- Invalid multi-key: `chaves` = 1001 applied in one cycle and held. Expect one `jogada_invalida` pulse, no `jogada_feita`, `jogada` unchanged, state 2 until release, then 0.
- Disabled press: `habilita` = 0, `chaves` = 0010 held. Then raise `habilita` while still held. Expect no pulse and state 2. After release and a re-press with `habilita` = 1, expect exactly one `jogada_feita` with `jogada` = 0010.
- Extra key and limpa: press 0001 (accepted), then add 0100 while held. Expect state 1→2 with no additional strobe, `jogada` stays 0001. Assert `limpa` for 1 cycle: `jogada` = 0000.
- Async reset mid-operation: drop `reset` to 0 between clock edges during debounce of 1000. Expect all outputs 0 immediately. After release with the key held, expect one pulse 7 cycles after the first clock edge with `reset` = 1.
